rtc_timekeeper: RTL

Real-time clock core that sits directly upstream of Display_Subsystem and drives its sec/min/hour inputs in CLOCK mode. A parameterised prescaler divides the system clock down to a 1 Hz tick, and cascaded BCD-free binary counters advance HH:MM:SS in 24 h format. The block provides a validated parallel load port and per-field increment inputs for time setting while stopped. Outputs are registered and glitch-free for the display multiplexer.

---
 rtl/rtc_pkg.sv | 22 ++
 rtl/rtc_prescaler.sv | 34 +++
 rtl/rtc_timekeeper.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared widths, limits and time record for the RTC timekeeper.
package rtc_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_t;

  function automatic logic time_legal(input time_t t);
    return (t.sec <= SEC_MAX) && (t.min <= MIN_MAX) && (t.hour <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ enabled cycles.
module rtc_prescaler #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int PRESC_W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRESC_W-1:0] TC = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  // Tick is only meaningful while counting; a frozen count at TC must not re-fire.
  assign tick = en && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// 24 h HH:MM:SS real-time clock with load/set ports; RTC_ALARM_EN adds an hh:mm alarm.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int PRESC_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              load_valid,
  input  logic [SEC_W-1:0]  load_sec,
  input  logic [MIN_W-1:0]  load_min,
  input  logic [HOUR_W-1:0] load_hour,
  input  logic              inc_min,
  input  logic              inc_hour,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              tick_1hz,
  output logic              day_wrap,
  output logic              load_err
`ifdef RTC_ALARM_EN
  ,
  input  logic              alarm_set,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic              alarm_ack,
  output logic              alarm
`endif
);

  time_t time_q, time_d, load_t;
  logic  tick_q, tick_d;
  logic  wrap_q, wrap_d;
  logic  err_q, err_d;
  logic  load_ok, load_acc, presc_tick, alarm_err;

  assign load_t   = '{hour: load_hour, min: load_min, sec: load_sec};
  assign load_ok  = time_legal(load_t);
  assign load_acc = load_valid && load_ok;

  // Only an accepted load realigns the second boundary; a rejected one leaves phase alone.
  rtc_prescaler #(.CLK_HZ(CLK_HZ), .PRESC_W(PRESC_W)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (load_acc),
    .tick (presc_tick)
  );

  always_comb begin
    time_d = time_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = (load_valid && !load_ok) || alarm_err;
    if (load_acc) begin
      time_d = load_t;
    end else if (presc_tick) begin
      tick_d = 1'b1;
      if (time_q.sec == SEC_MAX) begin
        time_d.sec = '0;
        if (time_q.min == MIN_MAX) begin
          time_d.min = '0;
          if (time_q.hour == HOUR_MAX) begin
            time_d.hour = '0;
            wrap_d      = 1'b1;
          end else begin
            time_d.hour = time_q.hour + 1'b1;
          end
        end else begin
          time_d.min = time_q.min + 1'b1;
        end
      end else begin
        time_d.sec = time_q.sec + 1'b1;
      end
    end else if (!run && !load_valid) begin
      // Set mode: fields roll independently, no carry between them.
      if (inc_min) begin
        time_d.min = (time_q.min == MIN_MAX) ? '0 : time_q.min + 1'b1;
        time_d.sec = '0;
      end
      if (inc_hour) begin
        time_d.hour = (time_q.hour == HOUR_MAX) ? '0 : time_q.hour + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      time_q <= time_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign sec      = time_q.sec;
  assign min      = time_q.min;
  assign hour     = time_q.hour;
  assign tick_1hz = tick_q;
  assign day_wrap = wrap_q;
  assign load_err = err_q;

`ifdef RTC_ALARM_EN
  logic [MIN_W-1:0]  amin_q, amin_d;
  logic [HOUR_W-1:0] ahour_q, ahour_d;
  logic              armed_q, armed_d;
  logic              alarm_q, alarm_d;
  logic              alarm_ok, alarm_hit;

  assign alarm_ok  = (alarm_min <= MIN_MAX) && (alarm_hour <= HOUR_MAX);
  assign alarm_err = alarm_set && !alarm_ok;
  // Match only on a real advance onto second zero, never on a load or set-mode edit.
  assign alarm_hit = armed_q && tick_d && (time_d.sec == '0) &&
                     (time_d.min == amin_q) && (time_d.hour == ahour_q);

  always_comb begin
    amin_d  = amin_q;
    ahour_d = ahour_q;
    armed_d = armed_q;
    alarm_d = alarm_q;
    if (alarm_set && alarm_ok) begin
      amin_d  = alarm_min;
      ahour_d = alarm_hour;
      armed_d = 1'b1;
    end
    if (alarm_hit)      alarm_d = 1'b1;
    else if (alarm_ack) alarm_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      amin_q  <= '0;
      ahour_q <= '0;
      armed_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      amin_q  <= amin_d;
      ahour_q <= ahour_d;
      armed_q <= armed_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm_err = 1'b0;
`endif

endmodule
